debug_channel_arbiter: RTL and testbench

- Collects change events from CHANNELS change-detecting capture units. Each unit presents a trigger and an 8-bit data word.
- Snapshots each event into a per-channel pending slot.
- Serialises pending records, round-robin, onto one valid/ready stream toward the Ethernet TX framer.
- Also drives the per-channel capture-unit enables from host-side arm and mask configuration, and counts events lost to overwrite.

---
 rtl/debug_channel_arbiter.sv | 169 ++++++++++++++++
 tb/tb_debug_channel_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_channel_arbiter.sv
// debug_channel_arbiter: per-channel event snapshot slots drained
// round-robin onto one valid/ready record stream.
module debug_channel_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ID_W     = $clog2(CHANNELS),
  parameter int DATA_W   = 8,
  parameter int SEQ_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [CHANNELS-1:0]        ch_mask,
  output logic [CHANNELS-1:0]        enabled,
  input  logic [CHANNELS-1:0]        trigger,
  input  logic [CHANNELS*DATA_W-1:0] data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [ID_W-1:0]            tx_chan,
  output logic [DATA_W-1:0]          tx_data,
  output logic [SEQ_W-1:0]           tx_seq,
  output logic                       tx_overrun,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  state_t state_q, state_d;

  logic [CHANNELS-1:0] enabled_q;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] lost_q, lost_d;

  logic [CHANNELS-1:0][DATA_W-1:0] snap_q, snap_d;

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic              grant_en;
  logic [SEQ_W-1:0]  seq_q;
  logic [15:0]       drop_q, drop_d;
  logic [4:0]        drops;
  logic [16:0]       drop_sum;

  logic [ID_W-1:0]   tx_chan_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [SEQ_W-1:0]  tx_seq_q;
  logic              tx_ovr_q;

  assign qual = trigger & enabled_q;

  // capture-unit enables follow host arm/mask one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) enabled_q <= '0;
    else       enabled_q <= {CHANNELS{arm}} & ch_mask;
  end

  // round-robin search: first pending slot at or after ptr_q
  always_comb begin
    int idx;
    logic [ID_W-1:0] id_k;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx  = (int'(ptr_q) + k) % CHANNELS;
      id_k = ID_W'(idx);
      if (pending_q[id_k]) begin
        gnt_vld = 1'b1;
        gnt_idx = id_k;
      end
    end
  end

  // next state: grant from IDLE, release on handshake
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant_en = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // slot update: newest data wins, overwrites flagged and counted
  always_comb begin
    logic gi;
    pending_d = pending_q;
    lost_d    = lost_q;
    snap_d    = snap_q;
    drops     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      gi = grant_en && (gnt_idx == ID_W'(i));
      if (qual[i]) begin
        snap_d[i]    = data[i*DATA_W +: DATA_W];
        pending_d[i] = 1'b1;
        if (gi) begin
          lost_d[i] = 1'b0;
        end else if (pending_q[i]) begin
          lost_d[i] = 1'b1;
          drops     = drops + 5'd1;
        end
      end else if (gi) begin
        pending_d[i] = 1'b0;
        lost_d[i]    = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // state and slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      lost_q    <= '0;
      snap_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      snap_q    <= snap_d;
      drop_q    <= drop_d;
    end
  end

  // record output register, sequence and pointer advance on grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_chan_q <= '0;
      tx_data_q <= '0;
      tx_seq_q  <= '0;
      tx_ovr_q  <= 1'b0;
      seq_q     <= '0;
      ptr_q     <= '0;
    end else if (grant_en) begin
      tx_chan_q <= gnt_idx;
      tx_data_q <= snap_q[gnt_idx];
      tx_seq_q  <= seq_q;
      tx_ovr_q  <= lost_q[gnt_idx];
      seq_q     <= seq_q + 1'b1;
      ptr_q     <= (gnt_idx == ID_W'(CHANNELS - 1))
                   ? '0 : gnt_idx + 1'b1;
    end
  end

  assign enabled    = enabled_q;
  assign tx_valid   = (state_q == SEND);
  assign tx_chan    = tx_chan_q;
  assign tx_data    = tx_data_q;
  assign tx_seq     = tx_seq_q;
  assign tx_overrun = tx_ovr_q;
  assign drop_count = drop_q;
  assign busy       = (state_q == SEND) | (|pending_q);

endmodule

// File: tb/tb_debug_channel_arbiter.sv
// tb_debug_channel_arbiter: vector table plus scoreboard of
// expected records checked at every handshake.
module tb_debug_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [3:0]  ch_mask;
  logic [3:0]  enabled;
  logic [3:0]  trigger;
  logic [31:0] data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_chan;
  logic [7:0]  tx_data;
  logic [7:0]  tx_seq;
  logic        tx_overrun;
  logic [15:0] drop_count;
  logic        busy;

  debug_channel_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .ch_mask    (ch_mask),
    .enabled    (enabled),
    .trigger    (trigger),
    .data       (data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_chan    (tx_chan),
    .tx_data    (tx_data),
    .tx_seq     (tx_seq),
    .tx_overrun (tx_overrun),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
    logic [7:0] seq;
    logic       ovr;
  } rec_t;

  typedef struct {
    logic       arm;
    logic [3:0] mask;
    int         ch;
    logic [7:0] d;
    logic [3:0] exp_en;
    logic       exp_rec;
  } vec_t;

  rec_t       sb[$];
  int         hs_cyc[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_seq = 8'd0;
  vec_t       vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input int ch, input logic [7:0] d,
                            input logic o);
    rec_t r;
    r.chan = 2'(ch);
    r.data = d;
    r.seq  = exp_seq;
    r.ovr  = o;
    sb.push_back(r);
    exp_seq++;
  endtask

  task automatic pulse(input logic [3:0] t, input logic [31:0] d);
    trigger = t;
    data    = d;
    step();
    trigger = '0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < lim) begin
      step();
      n++;
    end
    chk("drain_done", {31'b0, (sb.size() == 0) && !busy}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    sb.delete();
    exp_seq = 8'd0;
    step();
  endtask

  // scoreboard: compare every accepted record with the oldest expected one
  always @(negedge clk) begin
    rec_t e;
    if (!reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rec actual=ch%0d/%h required=none",
                 tx_chan, tx_data);
      end else begin
        e = sb.pop_front();
        chk("rec_chan", 32'(tx_chan), 32'(e.chan));
        chk("rec_data", 32'(tx_data), 32'(e.data));
        chk("rec_seq",  32'(tx_seq),  32'(e.seq));
        chk("rec_ovr",  32'(tx_overrun), 32'(e.ovr));
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic [7:0] s;
    vecs[0] = '{1'b1, 4'b0001, 0, 8'h5A, 4'b0001, 1'b1};
    vecs[1] = '{1'b1, 4'b1111, 3, 8'hC3, 4'b1111, 1'b1};
    vecs[2] = '{1'b1, 4'b1101, 1, 8'h77, 4'b1101, 1'b0};
    vecs[3] = '{1'b1, 4'b1101, 2, 8'h81, 4'b1101, 1'b1};
    vecs[4] = '{1'b0, 4'b1111, 2, 8'h99, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, 4'b0110, 2, 8'hAA, 4'b0110, 1'b1};

    reset    = 1'b1;
    arm      = 1'b0;
    ch_mask  = '0;
    trigger  = '0;
    data     = '0;
    tx_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_en",    32'(enabled), 32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    chk("rst_seq",   32'(tx_seq), 32'd0);
    reset = 1'b0;
    arm     = 1'b1;
    ch_mask = 4'b0001;
    step();
    chk("en_latency", 32'(enabled), 32'h1);

    // single event latency and fields
    pulse(4'b0001, 32'h5A);
    chk("lat_t1_valid", 32'(tx_valid), 32'd0);
    chk("lat_t1_busy",  32'(busy), 32'd1);
    step();
    chk("lat_t2_valid", 32'(tx_valid), 32'd1);
    chk("lat_chan", 32'(tx_chan), 32'd0);
    chk("lat_data", 32'(tx_data), 32'h5A);
    chk("lat_seq",  32'(tx_seq), 32'd0);
    chk("lat_ovr",  32'(tx_overrun), 32'd0);
    expect_rec(0, 8'h5A, 1'b0);
    tx_ready = 1'b1;
    drain(20);
    chk("lat_busy_end", 32'(busy), 32'd0);

    // four simultaneous events, round-robin order and rate
    do_reset();
    ch_mask = 4'b1111;
    step();
    hs_cyc.delete();
    pulse(4'b1111, 32'h44332211);
    expect_rec(0, 8'h11, 1'b0);
    expect_rec(1, 8'h22, 1'b0);
    expect_rec(2, 8'h33, 1'b0);
    expect_rec(3, 8'h44, 1'b0);
    drain(40);
    chk("rr_count", 32'(hs_cyc.size()), 32'd4);
    if (hs_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        chk("rr_gap", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd2);
    pulse(4'b0010, 32'h0000_B100);
    pulse(4'b0001, 32'h0000_00A0);
    expect_rec(1, 8'hB1, 1'b0);
    expect_rec(0, 8'hA0, 1'b0);
    drain(40);

    // overwrite while stalled
    tx_ready = 1'b0;
    s = exp_seq;
    pulse(4'b0100, 32'h0011_0000);
    pulse(4'b0100, 32'h0022_0000);
    pulse(4'b0100, 32'h0033_0000);
    chk("ovw_drop", 32'(drop_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_chan",  32'(tx_chan), 32'd2);
      chk("hold_data",  32'(tx_data), 32'h11);
      chk("hold_seq",   32'(tx_seq), 32'(s));
      step();
    end
    expect_rec(2, 8'h11, 1'b0);
    expect_rec(2, 8'h33, 1'b1);
    tx_ready = 1'b1;
    drain(40);

    // arm / mask qualification table
    for (int v = 0; v < 6; v++) begin
      arm     = vecs[v].arm;
      ch_mask = vecs[v].mask;
      step();
      chk("tbl_en", 32'(enabled), 32'(vecs[v].exp_en));
      pulse(4'(1 << vecs[v].ch), 32'(vecs[v].d) << (vecs[v].ch * 8));
      if (vecs[v].exp_rec) expect_rec(vecs[v].ch, vecs[v].d, 1'b0);
      drain(30);
    end

    // disarm with a record still pending
    arm     = 1'b1;
    ch_mask = 4'b1111;
    step();
    tx_ready = 1'b0;
    pulse(4'b0001, 32'h3C);
    arm = 1'b0;
    step();
    chk("disarm_en", 32'(enabled), 32'd0);
    pulse(4'b1000, 32'h5500_0000);
    chk("disarm_busy", 32'(busy), 32'd1);
    expect_rec(0, 8'h3C, 1'b0);
    tx_ready = 1'b1;
    drain(30);

    // sequence number wrap
    arm     = 1'b1;
    ch_mask = 4'b0001;
    step();
    for (int i = 0; i < 260; i++) begin
      pulse(4'b0001, 32'(i[7:0]));
      expect_rec(0, i[7:0], 1'b0);
      drain(20);
    end

    // drop counter saturation
    tx_ready = 1'b0;
    ch_mask  = 4'b1111;
    step();
    trigger = 4'b1111;
    data    = 32'hDEADBEEF;
    repeat (16500) step();
    chk("drop_sat", 32'(drop_count), 32'hFFFF);
    repeat (8) step();
    chk("drop_hold", 32'(drop_count), 32'hFFFF);
    trigger = '0;
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);

    // asynchronous reset mid-handshake
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_drop",  32'(drop_count), 32'd0);
    sb.delete();
    exp_seq = 8'd0;
    step();
    reset = 1'b0;
    step();
    chk("arst_en", 32'(enabled), 32'hF);
    pulse(4'b1010, 32'hD300_B100);
    expect_rec(1, 8'hB1, 1'b0);
    expect_rec(3, 8'hD3, 1'b0);
    tx_ready = 1'b1;
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
